// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC result feeder.
// FC_FEED_RELU_EN (defined in the top) selects ReLU on the replay path.
package fc_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned RELU_W         = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } feed_state_e;

  // Sign bit sits at position w-1; upper bits are zero-extended padding.
  function automatic logic [RELU_W-1:0] relu(input logic [RELU_W-1:0] v, input int unsigned w);
    return v[w-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/fc_result_feeder_if.sv
// Handshake bundle between the upstream FC layer, the feeder and the downstream FC layer.
interface fc_result_feeder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              layer_end;
  logic              hold;
  logic              next_enable;
  logic [DATA_W-1:0] next_value;
  logic              next_valid;
  logic              feed_done;
  logic              err_range;
  logic              err_overlap;

  modport master (
    output wr_en, wr_addr, wr_data, layer_end, hold,
    input  next_enable, next_value, next_valid, feed_done, err_range, err_overlap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, layer_end, hold,
    output next_enable, next_value, next_valid, feed_done, err_range, err_overlap
  );

endinterface

// File: rtl/fc_buf_ram.sv
// DEPTH x DATA_W simple dual-port RAM: one write port, one registered read port.
module fc_buf_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Same-edge write and read of one cell returns the new data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/fc_result_feeder.sv
// Captures an FC layer's (we, addr, out) result stream and replays it in address order.
// Define FC_FEED_RELU_EN to clamp negative replayed values to zero.
module fc_result_feeder
  import fc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 10
) (
  input logic              clk,
  input logic              reset,
  fc_result_feeder_if.slave bus
);

  feed_state_e       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              next_enable_q;
  logic [DATA_W-1:0] next_value_q;
  logic              next_valid_q;
  logic              feed_done_q;
  logic              err_range_q;
  logic              err_overlap_q;

  logic              accepting;
  logic              busy;
  logic              addr_ok;
  logic              wr_commit;
  logic              start;
  logic              last;
  logic              advance;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_value;

  always_comb begin
    accepting = (state_q == IDLE) || (state_q == CAPTURE);
    busy      = !accepting;
    addr_ok   = (32'(bus.wr_addr) < DEPTH);
    wr_commit = bus.wr_en && addr_ok && accepting;
    start     = accepting && bus.layer_end;
    last      = (idx_q == IDX_W'(DEPTH - 1));
    advance   = (state_q == STREAM) && !bus.hold;
    // Prefetch keeps rd_data equal to buf[idx_q] whenever the stream is waiting.
    rd_en     = start || (advance && !last);
    rd_addr   = start ? '0 : idx_q + IDX_W'(1);
  end

  fc_buf_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk  (clk),
    .we   (wr_commit),
    .waddr(bus.wr_addr[IDX_W-1:0]),
    .wdata(bus.wr_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

`ifdef FC_FEED_RELU_EN
  assign out_value = DATA_W'(relu(RELU_W'(rd_data), DATA_W));
`else
  assign out_value = rd_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      next_enable_q <= 1'b0;
      next_value_q  <= '0;
      next_valid_q  <= 1'b0;
      feed_done_q   <= 1'b0;
      err_range_q   <= 1'b0;
      err_overlap_q <= 1'b0;
    end else begin
      next_valid_q <= 1'b0;
      feed_done_q  <= 1'b0;
      if (bus.wr_en && !addr_ok) err_range_q <= 1'b1;
      if (bus.wr_en && busy) err_overlap_q <= 1'b1;

      unique case (state_q)
        IDLE, CAPTURE: begin
          if (bus.layer_end) begin
            state_q       <= STREAM;
            next_enable_q <= 1'b1;
            idx_q         <= '0;
          end else if (bus.wr_en) begin
            state_q <= CAPTURE;
          end
        end
        STREAM: begin
          if (!bus.hold) begin
            next_value_q <= out_value;
            next_valid_q <= 1'b1;
            if (last) state_q <= DONE;
            else      idx_q   <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_q       <= IDLE;
          idx_q         <= '0;
          next_enable_q <= 1'b0;
          feed_done_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.next_enable = next_enable_q;
  assign bus.next_value  = next_value_q;
  assign bus.next_valid  = next_valid_q;
  assign bus.feed_done   = feed_done_q;
  assign bus.err_range   = err_range_q;
  assign bus.err_overlap = err_overlap_q;

endmodule

// File: tb/tb_fc_result_feeder.sv
// Directed self-checking bench for fc_result_feeder (DEPTH = 10).
module tb_fc_result_feeder;

  localparam int TR = 20;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] tr_val [TR];
  logic        tr_vld [TR];
  logic        tr_en  [TR];
  logic        tr_done[TR];

  always #5 clk = ~clk;

  fc_result_feeder_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  fc_result_feeder #(
    .DATA_W(16),
    .DEPTH (10),
    .ADDR_W(16),
    .IDX_W (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int addr, input int val);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 16'(addr);
    bus.wr_data = 16'(val);
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Pulses layer_end (optionally with a same-cycle write) and records TR cycles from T.
  task automatic run_stream(input int hold_at, input int hold_len, input int wr_at,
                            input int rst_at, input bit end_wr);
    int nvalid = 0;
    int hleft  = 0;
    bit held   = 0;
    bus.layer_end = 1'b1;
    if (end_wr) begin
      bus.wr_en = 1'b1; bus.wr_addr = 16'd9; bus.wr_data = 16'd99;
    end
    step();
    bus.layer_end = 1'b0;
    bus.wr_en     = 1'b0;
    for (int c = 0; c < TR; c++) begin
      tr_val[c]  = bus.next_value;
      tr_vld[c]  = bus.next_valid;
      tr_en[c]   = bus.next_enable;
      tr_done[c] = bus.feed_done;
      if (bus.next_valid) nvalid++;
      bus.wr_en = 1'b0;
      if (c == wr_at) begin
        bus.wr_en = 1'b1; bus.wr_addr = 16'd3; bus.wr_data = 16'd555;
      end
      reset = (c == rst_at);
      if (hleft > 0) begin
        hleft--;
        if (hleft == 0) bus.hold = 1'b0;
      end
      if (nvalid == hold_at && !held) begin
        bus.hold = 1'b1; hleft = hold_len; held = 1;
      end
      step();
    end
    bus.wr_en = 1'b0;
    bus.hold  = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++;
    if (bus.next_enable !== 1'b0 || bus.next_valid !== 1'b0 || bus.feed_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: en=%b vld=%b done=%b, required 0 0 0",
               bus.next_enable, bus.next_valid, bus.feed_done);
    end
    n_checks++;
    if (bus.next_value !== 16'd0) begin
      n_fail++; $display("FAIL reset_value: got %0d, required 0", bus.next_value);
    end
    n_checks++;
    if (bus.err_range !== 1'b0 || bus.err_overlap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: range=%b overlap=%b, required 0 0", bus.err_range, bus.err_overlap);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_replay_basic();
    for (int i = 0; i < 10; i++) write_cell(i, i + 1);
    run_stream(-1, 0, -1, -1, 0);
    n_checks++;
    if (tr_en[0] !== 1'b1 || tr_vld[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_T: en=%b vld=%b, required 1 0", tr_en[0], tr_vld[0]);
    end
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (tr_vld[k] !== 1'b1 || tr_val[k] !== 16'(k) || tr_en[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_elem%0d: vld=%b val=%0d en=%b, required 1 %0d 1",
                 k, tr_vld[k], tr_val[k], tr_en[k], k);
      end
    end
    n_checks++;
    if (tr_done[10] !== 1'b0 || tr_done[11] !== 1'b1 || tr_en[11] !== 1'b0 || tr_vld[11] !== 1'b0
        || tr_done[12] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done10=%b done11=%b en11=%b vld11=%b done12=%b, required 0 1 0 0 0",
               tr_done[10], tr_done[11], tr_en[11], tr_vld[11], tr_done[12]);
    end
    n_checks++;
    if (bus.err_range !== 1'b0 || bus.err_overlap !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: range=%b overlap=%b, required 0 0", bus.err_range, bus.err_overlap);
    end
  endtask

  task automatic test_negative();
    logic [15:0] e;
    for (int i = 0; i < 10; i++) write_cell(i, -250 + 3 * i);
    run_stream(-1, 0, -1, -1, 0);
    for (int k = 1; k <= 10; k++) begin
`ifdef FC_FEED_RELU_EN
      e = 16'd0;
`else
      e = 16'(-250 + 3 * (k - 1));
`endif
      n_checks++;
      if (tr_vld[k] !== 1'b1 || tr_val[k] !== e) begin
        n_fail++;
        $display("FAIL negative_elem%0d: vld=%b val=%0d, required 1 %0d",
                 k, tr_vld[k], $signed(tr_val[k]), $signed(e));
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] ev;
    logic        evld;
    for (int i = 0; i < 10; i++) write_cell(i, i + 1);
    run_stream(4, 3, -1, -1, 0);
    for (int c = 1; c <= 14; c++) begin
      if (c <= 4)      begin ev = 16'(c);     evld = 1'b1; end
      else if (c <= 7) begin ev = 16'd4;      evld = 1'b0; end
      else if (c <= 13) begin ev = 16'(c - 3); evld = 1'b1; end
      else             begin ev = 16'd10;     evld = 1'b0; end
      n_checks++;
      if (tr_vld[c] !== evld || tr_val[c] !== ev || tr_done[c] !== (c == 14)) begin
        n_fail++;
        $display("FAIL hold_c%0d: vld=%b val=%0d done=%b, required %b %0d %b",
                 c, tr_vld[c], tr_val[c], tr_done[c], evld, ev, (c == 14));
      end
    end
  endtask

  task automatic test_errors();
    write_cell(12, 7);
    n_checks++;
    if (bus.err_range !== 1'b1 || bus.err_overlap !== 1'b0) begin
      n_fail++;
      $display("FAIL range_err: range=%b overlap=%b, required 1 0", bus.err_range, bus.err_overlap);
    end
    run_stream(-1, 0, 2, -1, 0);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (tr_vld[k] !== 1'b1 || tr_val[k] !== 16'(k)) begin
        n_fail++;
        $display("FAIL overlap_elem%0d: vld=%b val=%0d, required 1 %0d", k, tr_vld[k], tr_val[k], k);
      end
    end
    n_checks++;
    if (bus.err_overlap !== 1'b1 || bus.err_range !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_err: overlap=%b range=%b, required 1 1", bus.err_overlap, bus.err_range);
    end
  endtask

  task automatic test_same_cycle();
    write_cell(0, 1);
    run_stream(-1, 0, -1, -1, 1);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (tr_vld[k] !== 1'b1 || tr_val[k] !== ((k == 10) ? 16'd99 : 16'(k))) begin
        n_fail++;
        $display("FAIL samecycle_elem%0d: vld=%b val=%0d, required 1 %0d",
                 k, tr_vld[k], tr_val[k], (k == 10) ? 99 : k);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_stream(-1, 0, -1, 5, 0);
    n_checks++;
    if (tr_vld[5] !== 1'b1 || tr_val[5] !== 16'd5) begin
      n_fail++; $display("FAIL rstmid_pre: vld=%b val=%0d, required 1 5", tr_vld[5], tr_val[5]);
    end
    for (int c = 6; c < TR; c++) begin
      n_checks++;
      if (tr_vld[c] !== 1'b0 || tr_en[c] !== 1'b0 || tr_done[c] !== 1'b0 || tr_val[c] !== 16'd0) begin
        n_fail++;
        $display("FAIL rstmid_c%0d: vld=%b en=%b done=%b val=%0d, required 0 0 0 0",
                 c, tr_vld[c], tr_en[c], tr_done[c], tr_val[c]);
      end
    end
    n_checks++;
    if (bus.err_range !== 1'b0 || bus.err_overlap !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_err: range=%b overlap=%b, required 0 0", bus.err_range, bus.err_overlap);
    end
    run_stream(-1, 0, -1, -1, 0);
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if (tr_vld[k] !== 1'b1 || tr_val[k] !== ((k == 10) ? 16'd99 : 16'(k))) begin
        n_fail++;
        $display("FAIL rstmid_replay%0d: vld=%b val=%0d, required 1 %0d",
                 k, tr_vld[k], tr_val[k], (k == 10) ? 99 : k);
      end
    end
    n_checks++;
    if (tr_done[11] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_done: done=%b, required 1", tr_done[11]);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.layer_end = 1'b0;
    bus.hold      = 1'b0;
    test_reset();
    test_replay_basic();
    test_negative();
    test_hold();
    test_errors();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
